// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divider sequencer: op encodings, FSM states, defaults.
package div_ctrl_pkg;

    // Bit 0 clear marks the signed ops, bit 1 set marks the remainder ops.
    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SPECIAL = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4,
        ST_HIT     = 3'd5
    } div_state_e;

    localparam int XLEN_DEF    = 64;
    localparam int TIMEOUT_DEF = 96;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_ctrl_special_detect.sv
// Combinational RISC-V divide special cases (divide-by-zero, signed overflow) on prepared operands.
module div_special_detect
    import div_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            is_special,
    output logic [XLEN-1:0] special_result
);

    logic            b_zero;
    logic            is_ovf;
    logic [XLEN-1:0] min_val;
    logic [XLEN-1:0] raw;

    // W operands are already sign-extended, so the W most-negative value carries ones above bit 31.
    assign min_val = word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign b_zero  = (b == '0);
    assign is_ovf  = op_is_signed(op) & (a == min_val) & (&b);

    always_comb begin
        raw = '0;
        if (b_zero) begin
            raw = op_is_rem(op) ? a : '1;
        end else begin
            raw = op_is_rem(op) ? '0 : a;
        end
    end

    assign is_special     = b_zero | is_ovf;
    assign special_result = word ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between EX and the shared iterative divider: special cases, launch, timeout, flush.
// Optional DIV_CACHE_EN keeps the last divider result so a matching DIV/REM pair skips the divider.
//
// state   | meaning
// IDLE    | waiting for a request from EX
// SPECIAL | special-case result ready, respond for one cycle
// LAUNCH  | pulse div_start_o, clear the timeout counter
// WAIT    | divider busy, counting towards timeout
// DONE    | divider (or timeout) result ready, respond for one cycle
// HIT     | cached result ready, respond for one cycle
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid_i,
    input  logic [1:0]      req_op_i,
    input  logic            req_word_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_data_o,
    output logic            err_o,
    output logic            div_start_o,
    output logic            div_abort_o,
    output logic            div_signed_o,
    output logic [XLEN-1:0] div_a_o,
    output logic [XLEN-1:0] div_b_o,
    input  logic            div_ready_i,
    input  logic [XLEN-1:0] div_q_i,
    input  logic [XLEN-1:0] div_r_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    div_state_e      state, state_nxt;
    logic [1:0]      op_q;
    logic            word_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [CW-1:0]   cnt;

    logic            sgn_in;
    logic [XLEN-1:0] a_prep, b_prep;
    logic            is_special;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] div_sel, div_res;
    logic            res_load;
    logic [XLEN-1:0] res_nxt;
    logic            err_set;
    logic            div_cmpl;

    assign sgn_in = op_is_signed(req_op_i);
    assign a_prep = req_word_i ? {{(XLEN-32){sgn_in & req_a_i[31]}}, req_a_i[31:0]} : req_a_i;
    assign b_prep = req_word_i ? {{(XLEN-32){sgn_in & req_b_i[31]}}, req_b_i[31:0]} : req_b_i;

    div_special_detect #(.XLEN(XLEN)) u_special (
        .op             (req_op_i),
        .word           (req_word_i),
        .a              (a_prep),
        .b              (b_prep),
        .is_special     (is_special),
        .special_result (special_result)
    );

    assign div_sel  = op_is_rem(op_q) ? div_r_i : div_q_i;
    assign div_res  = word_q ? {{(XLEN-32){div_sel[31]}}, div_sel[31:0]} : div_sel;
    assign div_cmpl = (state == ST_WAIT) & ~flush_i & div_ready_i;

`ifdef DIV_CACHE_EN
    logic            c_valid;
    logic [XLEN-1:0] c_a, c_b, c_q, c_r;
    logic            c_signed, c_word;
    logic            cache_hit;
    logic [XLEN-1:0] c_sel, cache_res;

    assign cache_hit = c_valid & (c_a == a_prep) & (c_b == b_prep) &
                       (c_signed == sgn_in) & (c_word == req_word_i);
    assign c_sel     = op_is_rem(req_op_i) ? c_r : c_q;
    assign cache_res = req_word_i ? {{(XLEN-32){c_sel[31]}}, c_sel[31:0]} : c_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            c_valid  <= 1'b0;
            c_a      <= '0;
            c_b      <= '0;
            c_q      <= '0;
            c_r      <= '0;
            c_signed <= 1'b0;
            c_word   <= 1'b0;
        end else if (err_set) begin
            c_valid <= 1'b0;
        end else if (div_cmpl) begin
            c_valid  <= 1'b1;
            c_a      <= a_q;
            c_b      <= b_q;
            c_q      <= div_q_i;
            c_r      <= div_r_i;
            c_signed <= op_is_signed(op_q);
            c_word   <= word_q;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        res_load  = 1'b0;
        res_nxt   = '0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid_i & ~flush_i) begin
                    if (is_special) begin
                        state_nxt = ST_SPECIAL;
                        res_load  = 1'b1;
                        res_nxt   = special_result;
                    end
`ifdef DIV_CACHE_EN
                    else if (cache_hit) begin
                        state_nxt = ST_HIT;
                        res_load  = 1'b1;
                        res_nxt   = cache_res;
                    end
`endif
                    else begin
                        state_nxt = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: state_nxt = flush_i ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (flush_i) begin
                    state_nxt = ST_IDLE;
                end else if (div_ready_i) begin
                    state_nxt = ST_DONE;
                    res_load  = 1'b1;
                    res_nxt   = div_res;
                end else if (cnt == TO_CNT) begin
                    state_nxt = ST_DONE;
                    res_load  = 1'b1;
                    err_set   = 1'b1;
                end
            end
            ST_SPECIAL, ST_DONE, ST_HIT: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            resp_data_o <= '0;
            err_o       <= 1'b0;
            op_q        <= 2'd0;
            word_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_LAUNCH) begin
                cnt <= '0;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (res_load) begin
                resp_data_o <= res_nxt;
            end
            if (err_set) begin
                err_o <= 1'b1;
            end
            // EX holds the request stable while stalled, so capture once on acceptance.
            if (state == ST_IDLE) begin
                op_q   <= req_op_i;
                word_q <= req_word_i;
                a_q    <= a_prep;
                b_q    <= b_prep;
            end
        end
    end

    assign resp_valid_o = ((state == ST_SPECIAL) | (state == ST_DONE) | (state == ST_HIT)) &
                          ~flush_i & ~reset;
    assign stall_o      = req_valid_i & ~resp_valid_o & ~flush_i;
    assign div_start_o  = (state == ST_LAUNCH) & ~flush_i & ~reset;
    assign div_abort_o  = ((state == ST_LAUNCH) | (state == ST_WAIT)) & flush_i & ~reset;
    assign div_signed_o = op_is_signed(op_q);
    assign div_a_o      = a_q;
    assign div_b_o      = b_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed corner cases plus randomized ops against a RISC-V reference model.
`timescale 1ns/1ps
module tb_div_ctrl;

    localparam int TIMEOUT = 96;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic [1:0]  req_op_i;
    logic        req_word_i;
    logic [63:0] req_a_i, req_b_i;
    logic        flush_i;
    logic        stall_o, resp_valid_o, err_o;
    logic [63:0] resp_data_o;
    logic        div_start_o, div_abort_o, div_signed_o;
    logic [63:0] div_a_o, div_b_o;
    logic        div_ready_i;
    logic [63:0] div_q_i, div_r_i;

    div_ctrl #(.XLEN(64), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_op_i     (req_op_i),
        .req_word_i   (req_word_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .err_o        (err_o),
        .div_start_o  (div_start_o),
        .div_abort_o  (div_abort_o),
        .div_signed_o (div_signed_o),
        .div_a_o      (div_a_o),
        .div_b_o      (div_b_o),
        .div_ready_i  (div_ready_i),
        .div_q_i      (div_q_i),
        .div_r_i      (div_r_i)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_data[$];
    logic        exp_err[$];
    int          n_start = 0;
    int          n_abort = 0;
    logic        err_model = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic is_sgn(input logic [1:0] op);
        return (op == 2'd0) || (op == 2'd2);
    endfunction

    function automatic logic ref_special(input logic [1:0] op, input logic word,
                                         input logic [63:0] a, input logic [63:0] b);
        if (word)
            return (b[31:0] == 32'd0) ||
                   (is_sgn(op) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) ||
               (is_sgn(op) && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
        logic        sgn, rem;
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        sgn = is_sgn(op);
        rem = (op >= 2'd2);
        a32 = a[31:0];
        b32 = b[31:0];
        if (word) begin
            if (b32 == 0)                                            r32 = rem ? a32 : 32'hFFFF_FFFF;
            else if (sgn && a32 == 32'h8000_0000 && b32 == '1)      r32 = rem ? 32'd0 : a32;
            else if (sgn) r32 = rem ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
            else          r32 = rem ? a32 % b32 : a32 / b32;
            return sext32(r32);
        end
        if (b == 0)                                                  r64 = rem ? a : '1;
        else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1)    r64 = rem ? 64'd0 : a;
        else if (sgn) r64 = rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        else          r64 = rem ? a % b : a / b;
        return r64;
    endfunction

    function automatic logic [63:0] prep(input logic [63:0] v, input logic word, input logic sgn);
        if (!word) return v;
        return {{32{sgn & v[31]}}, v[31:0]};
    endfunction

    logic        c_valid = 1'b0;
    logic [63:0] c_a, c_b;
    logic        c_s, c_w;

    // ---------------- divider model ----------------
    int          dly = 10;
    bit          armed = 0;
    int          dcnt = 0;
    logic [63:0] la, lb;
    logic        ls;

    always @(negedge clock) begin
        if (reset || div_abort_o) armed = 0;
        else if (div_start_o) begin
            armed = (dly > 0);
            dcnt  = dly;
            la    = div_a_o;
            lb    = div_b_o;
            ls    = div_signed_o;
        end
        if (div_start_o) n_start++;
        if (div_abort_o) n_abort++;
    end

    initial begin
        div_ready_i = 1'b0;
        div_q_i = '0;
        div_r_i = '0;
        forever begin
            @(posedge clock);
            #1;
            div_ready_i = 1'b0;
            div_q_i = {$urandom, $urandom};
            div_r_i = {$urandom, $urandom};
            if (armed) begin
                dcnt--;
                if (dcnt == 0) begin
                    armed = 0;
                    div_ready_i = 1'b1;
                    if (ls) begin
                        div_q_i = $signed(la) / $signed(lb);
                        div_r_i = $signed(la) % $signed(lb);
                    end else begin
                        div_q_i = la / lb;
                        div_r_i = la % lb;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [63:0] mon_d;
    logic        mon_e;
    always @(negedge clock) begin
        if (!reset && resp_valid_o) begin
            if (exp_data.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid with data %h, expected no response", resp_data_o);
            end else begin
                mon_d = exp_data.pop_front();
                mon_e = exp_err.pop_front();
                check("resp_data", resp_data_o, mon_d);
                check("resp_err", {63'd0, err_o}, {63'd0, mon_e});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input string name, input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input int delay, input int flush_at);
        int          lat, stall_n, starts0, aborts0;
        bit          special, hit, launched, timed_out, done;
        logic [63:0] pa, pb, expv;
        lat = 0; stall_n = 0; done = 0;
        special = ref_special(op, word, a, b);
        pa = prep(a, word, is_sgn(op));
        pb = prep(b, word, is_sgn(op));
        hit = 0;
`ifdef DIV_CACHE_EN
        hit = !special && c_valid && c_a == pa && c_b == pb && c_s == is_sgn(op) && c_w == word;
`endif
        launched  = !special && !hit;
        timed_out = launched && delay <= 0;
        expv      = timed_out ? 64'd0 : ref_result(op, word, a, b);
        dly       = delay;
        starts0   = n_start;
        aborts0   = n_abort;

        @(posedge clock);
        #1;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_word_i  = word;
        req_a_i     = a;
        req_b_i     = b;
        if (flush_at < 0) begin
            if (timed_out) err_model = 1'b1;
            exp_data.push_back(expv);
            exp_err.push_back(err_model);
        end

        while (!done) begin
            @(negedge clock);
            lat++;
            if (stall_o) stall_n++;
            if (flush_at > 0 && lat == flush_at) begin
                check({name, "_abort"}, {63'd0, div_abort_o}, 64'd1);
                check({name, "_flush_stall"}, {63'd0, stall_o}, 64'd0);
                done = 1;
            end else if (resp_valid_o) begin
                done = 1;
            end else if (lat > 400) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_no_resp: got no response in %0d cycles, expected one", name, lat);
                done = 1;
            end
            if (!done && flush_at > 0 && lat + 1 == flush_at) begin
                @(posedge clock);
                #1;
                flush_i = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;

        if (flush_at > 0) begin
            check({name, "_aborts"}, 64'(n_abort - aborts0), 64'd1);
            check({name, "_starts"}, 64'(n_start - starts0), 64'd1);
        end else begin
            check({name, "_starts"}, 64'(n_start - starts0), {63'd0, launched});
            check({name, "_stall_cycles"}, 64'(stall_n), 64'(lat - 1));
            if (timed_out)
                check({name, "_latency_window"},
                      {63'd0, (lat >= TIMEOUT + 3) && (lat <= TIMEOUT + 4)}, 64'd1);
            else if (launched)
                check({name, "_latency"}, 64'(lat), 64'(delay + 3));
            else
                check({name, "_latency"}, 64'(lat), 64'd2);
            if (timed_out) c_valid = 1'b0;
            else if (launched) begin
                c_valid = 1'b1;
                c_a = pa; c_b = pb; c_s = is_sgn(op); c_w = word;
            end
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return {$urandom, $urandom};
            1: return 64'($signed($urandom_range(0, 18)) - 9);
            2: return 64'd0;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'h8000_0000_0000_0000;
            default: return {32'h0000_0001 * $urandom_range(0, 1), 32'h8000_0000 | $urandom_range(0, 3)};
        endcase
    endfunction

    initial begin
        reset       = 1'b1;
        req_valid_i = 1'b0;
        req_op_i    = 2'd0;
        req_word_i  = 1'b0;
        req_a_i     = '0;
        req_b_i     = '0;
        flush_i     = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
        check("rst_resp_data", resp_data_o, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);
        check("rst_start", {63'd0, div_start_o}, 64'd0);
        check("rst_abort", {63'd0, div_abort_o}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_op("divu_100_7", 2'd1, 1'b0, 64'd100, 64'd7, 33, -1);
        run_op("div_by_zero", 2'd0, 1'b0, 64'd5, 64'd0, 10, -1);
        run_op("remuw_by_zero", 2'd3, 1'b1, 64'h1_0000_0005, 64'd0, 10, -1);
        run_op("divw_ovf", 2'd0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 10, -1);
        run_op("rem_ovf", 2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 10, -1);
        run_op("flush_wait", 2'd0, 1'b0, 64'd1000, 64'd9, 50, 13);
        repeat (4) @(negedge clock);
        run_op("after_flush", 2'd0, 1'b0, 64'd1000, 64'd9, 5, -1);
        run_op("div_m20_3", 2'd0, 1'b0, -64'sd20, 64'd3, 12, -1);
        run_op("rem_m20_3", 2'd2, 1'b0, -64'sd20, 64'd3, 12, -1);
        run_op("divuw_hi", 2'd1, 1'b1, 64'hDEAD_F000_0000_0010, 64'h1234_5678_0000_0003, 4, -1);

        for (int i = 0; i < 40; i++)
            run_op("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(),
                   $urandom_range(1, 40), -1);

        run_op("timeout", 2'd1, 1'b0, 64'd77, 64'd11, 0, -1);
        check("err_sticky", {63'd0, err_o}, 64'd1);
        run_op("after_timeout", 2'd1, 1'b0, 64'd77, 64'd11, 6, -1);

        // Reset in the middle of a divide: no abort, sticky error cleared.
        dly = 0;
        @(posedge clock);
        #1;
        req_valid_i = 1'b1; req_op_i = 2'd0; req_word_i = 1'b0; req_a_i = 64'd500; req_b_i = 64'd7;
        repeat (6) @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        req_valid_i = 1'b0;
        @(negedge clock);
        check("midrst_abort", {63'd0, div_abort_o}, 64'd0);
        check("midrst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        err_model = 1'b0;
        c_valid = 1'b0;
        @(negedge clock);
        check("midrst_err", {63'd0, err_o}, 64'd0);
        check("midrst_data", resp_data_o, 64'd0);
        run_op("after_reset", 2'd2, 1'b0, 64'd500, 64'd7, 8, -1);

        repeat (5) @(negedge clock);
        check("scoreboard_drained", 64'(exp_data.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
